// File: rtl/laser_cover_scheduler.sv
// rtl/laser_cover_scheduler.sv - alternating two-circle coverage search over a 16x16 grid
module laser_cover_scheduler #(
    parameter int NPTS       = 40,
    parameter int RADIUS_SQ  = 16,
    parameter int MAX_ROUNDS = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [3:0] pt_x,
    input  logic [3:0] pt_y,
    output logic [5:0] pt_addr,
    output logic [3:0] C1X,
    output logic [3:0] C1Y,
    output logic [3:0] C2X,
    output logic [3:0] C2Y,
    output logic [5:0] cover_cnt,
    output logic       busy,
    output logic       DONE
);
    localparam int RW = $clog2(MAX_ROUNDS + 1);
    localparam logic [5:0] LAST_ADDR = 6'(NPTS - 1);
    localparam logic [8:0] R2 = 9'(RADIUS_SQ);

    typedef enum logic [2:0] {IDLE, SCAN, EVAL, PHASE_END, DONE_ST} state_t;

    state_t        state_q, state_d;
    logic          phase_q, phase_d;      // 0: optimising C1, 1: optimising C2
    logic [RW-1:0] round_q, round_d;
    logic [5:0]    prev_best_q, prev_best_d;
    logic [3:0]    cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic [5:0]    acc_q, acc_d;
    logic [5:0]    pbest_q, pbest_d;
    logic [3:0]    pbx_q, pbx_d, pby_q, pby_d;
    logic [5:0]    addr_q, addr_d;
    logic [3:0]    c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;
    logic [5:0]    cover_q, cover_d;
    logic          busy_q, busy_d, done_q, done_d;

    logic [3:0]    fix_x, fix_y;
    logic          hit;
    logic [RW-1:0] round_nx;

    function automatic logic in_circle(input logic [3:0] px, input logic [3:0] py,
                                       input logic [3:0] cx, input logic [3:0] cy);
        logic [3:0] dx, dy;
        logic [7:0] dx2, dy2;
        logic [8:0] sum;
        dx  = (px >= cx) ? (px - cx) : (cx - px);
        dy  = (py >= cy) ? (py - cy) : (cy - py);
        dx2 = {4'd0, dx} * {4'd0, dx};
        dy2 = {4'd0, dy} * {4'd0, dy};
        sum = {1'b0, dx2} + {1'b0, dy2};
        return sum <= R2;
    endfunction

    // The circle not being optimised stays put for the whole sweep
    assign fix_x    = phase_q ? c1x_q : c2x_q;
    assign fix_y    = phase_q ? c1y_q : c2y_q;
    assign hit      = in_circle(pt_x, pt_y, cand_x_q, cand_y_q) | in_circle(pt_x, pt_y, fix_x, fix_y);
    assign round_nx = round_q + RW'(1);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        round_d     = round_q;
        prev_best_d = prev_best_q;
        cand_x_d    = cand_x_q;
        cand_y_d    = cand_y_q;
        acc_d       = acc_q;
        pbest_d     = pbest_q;
        pbx_d       = pbx_q;
        pby_d       = pby_q;
        addr_d      = addr_q;
        c1x_d       = c1x_q;
        c1y_d       = c1y_q;
        c2x_d       = c2x_q;
        c2y_d       = c2y_q;
        cover_d     = cover_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    c1x_d       = 4'd0;
                    c1y_d       = 4'd0;
                    c2x_d       = 4'd0;
                    c2y_d       = 4'd0;
                    cover_d     = 6'd0;
                    round_d     = '0;
                    prev_best_d = 6'd0;
                    phase_d     = 1'b0;
                    cand_x_d    = 4'd0;
                    cand_y_d    = 4'd0;
                    addr_d      = 6'd0;
                    acc_d       = 6'd0;
                    pbest_d     = 6'd0;
                    pbx_d       = 4'd0;
                    pby_d       = 4'd0;
                    busy_d      = 1'b1;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                acc_d = acc_q + {5'd0, hit};
                if (addr_q == LAST_ADDR) begin
                    state_d = EVAL;
                end else begin
                    addr_d = addr_q + 6'd1;
                end
            end
            EVAL: begin
                if (acc_q > pbest_q) begin
                    pbest_d = acc_q;
                    pbx_d   = cand_x_q;
                    pby_d   = cand_y_q;
                end
                {cand_y_d, cand_x_d} = {cand_y_q, cand_x_q} + 8'd1;
                if (&{cand_y_q, cand_x_q}) begin
                    state_d = PHASE_END;
                end else begin
                    acc_d   = 6'd0;
                    addr_d  = 6'd0;
                    state_d = SCAN;
                end
            end
            PHASE_END: begin
                acc_d   = 6'd0;
                addr_d  = 6'd0;
                pbest_d = 6'd0;
                pbx_d   = 4'd0;
                pby_d   = 4'd0;
                cover_d = pbest_q;
                if (!phase_q) begin
                    c1x_d   = pbx_q;
                    c1y_d   = pby_q;
                    phase_d = 1'b1;
                    state_d = SCAN;
                end else begin
                    c2x_d   = pbx_q;
                    c2y_d   = pby_q;
                    round_d = round_nx;
                    if (pbest_q > prev_best_q && int'(round_nx) < MAX_ROUNDS) begin
                        prev_best_d = pbest_q;
                        phase_d     = 1'b0;
                        state_d     = SCAN;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE_ST;
                    end
                end
            end
            DONE_ST: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            round_q     <= '0;
            prev_best_q <= 6'd0;
            cand_x_q    <= 4'd0;
            cand_y_q    <= 4'd0;
            acc_q       <= 6'd0;
            pbest_q     <= 6'd0;
            pbx_q       <= 4'd0;
            pby_q       <= 4'd0;
            addr_q      <= 6'd0;
            c1x_q       <= 4'd0;
            c1y_q       <= 4'd0;
            c2x_q       <= 4'd0;
            c2y_q       <= 4'd0;
            cover_q     <= 6'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            round_q     <= round_d;
            prev_best_q <= prev_best_d;
            cand_x_q    <= cand_x_d;
            cand_y_q    <= cand_y_d;
            acc_q       <= acc_d;
            pbest_q     <= pbest_d;
            pbx_q       <= pbx_d;
            pby_q       <= pby_d;
            addr_q      <= addr_d;
            c1x_q       <= c1x_d;
            c1y_q       <= c1y_d;
            c2x_q       <= c2x_d;
            c2y_q       <= c2y_d;
            cover_q     <= cover_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pt_addr   = addr_q;
    assign C1X       = c1x_q;
    assign C1Y       = c1y_q;
    assign C2X       = c2x_q;
    assign C2Y       = c2y_q;
    assign cover_cnt = cover_q;
    assign busy      = busy_q;
    assign DONE      = done_q;
endmodule

// File: tb/tb_laser_cover_scheduler.sv
// tb/tb_laser_cover_scheduler.sv - self-checking bench for laser_cover_scheduler
module tb_laser_cover_scheduler;
    localparam int NP = 8;
    localparam int L  = 256 * (NP + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start_a, start_b, sel;
    logic [3:0] px [NP];
    logic [3:0] py [NP];

    logic [5:0] addr_a, addr_b, cov_a, cov_b;
    logic [3:0] xa, ya, xb, yb;
    logic [3:0] c1x_a, c1y_a, c2x_a, c2y_a, c1x_b, c1y_b, c2x_b, c2y_b;
    logic       busy_a, busy_b, done_a, done_b;

    assign xa = (int'(addr_a) < NP) ? px[addr_a[2:0]] : 4'd0;
    assign ya = (int'(addr_a) < NP) ? py[addr_a[2:0]] : 4'd0;
    assign xb = (int'(addr_b) < NP) ? px[addr_b[2:0]] : 4'd0;
    assign yb = (int'(addr_b) < NP) ? py[addr_b[2:0]] : 4'd0;

    laser_cover_scheduler #(.NPTS(NP), .RADIUS_SQ(16), .MAX_ROUNDS(4)) dut (
        .CLK(clk), .RST(rst), .start(start_a), .pt_x(xa), .pt_y(ya), .pt_addr(addr_a),
        .C1X(c1x_a), .C1Y(c1y_a), .C2X(c2x_a), .C2Y(c2y_a), .cover_cnt(cov_a),
        .busy(busy_a), .DONE(done_a));

    laser_cover_scheduler #(.NPTS(NP), .RADIUS_SQ(16), .MAX_ROUNDS(1)) dut1 (
        .CLK(clk), .RST(rst), .start(start_b), .pt_x(xb), .pt_y(yb), .pt_addr(addr_b),
        .C1X(c1x_b), .C1Y(c1y_b), .C2X(c2x_b), .C2Y(c2y_b), .cover_cnt(cov_b),
        .busy(busy_b), .DONE(done_b));

    logic [3:0] o_c1x, o_c1y, o_c2x, o_c2y;
    logic [5:0] o_cov;
    logic       o_busy, o_done;
    assign o_c1x  = sel ? c1x_b : c1x_a;
    assign o_c1y  = sel ? c1y_b : c1y_a;
    assign o_c2x  = sel ? c2x_b : c2x_a;
    assign o_c2y  = sel ? c2y_b : c2y_a;
    assign o_cov  = sel ? cov_b : cov_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_done = sel ? done_b : done_a;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Search model: per-phase results after each phase end
    int m_p;
    int m_c1x [8];
    int m_c1y [8];
    int m_c2x [8];
    int m_c2y [8];
    int m_cov [8];

    function automatic bit covers(input int x, input int y, input int cx, input int cy);
        return (x - cx) * (x - cx) + (y - cy) * (y - cy) <= 16;
    endfunction

    task automatic run_model(input int mr);
        int c1x, c1y, c2x, c2y, prev, rnd, best, bx, by, cnt;
        bit pa;
        c1x = 0; c1y = 0; c2x = 0; c2y = 0; prev = 0; rnd = 0; pa = 1'b1;
        m_p = 0;
        while (m_p < 8) begin
            best = 0; bx = 0; by = 0;
            for (int y = 0; y < 16; y++) begin
                for (int x = 0; x < 16; x++) begin
                    cnt = 0;
                    for (int i = 0; i < NP; i++) begin
                        if (covers(px[i], py[i], x, y) ||
                            (pa ? covers(px[i], py[i], c2x, c2y) : covers(px[i], py[i], c1x, c1y)))
                            cnt++;
                    end
                    if (cnt > best) begin best = cnt; bx = x; by = y; end
                end
            end
            if (pa) begin c1x = bx; c1y = by; end
            else begin c2x = bx; c2y = by; end
            m_c1x[m_p] = c1x; m_c1y[m_p] = c1y; m_c2x[m_p] = c2x; m_c2y[m_p] = c2y;
            m_cov[m_p] = best;
            m_p++;
            if (pa) begin
                pa = 1'b0;
            end else begin
                rnd++;
                if (best > prev && rnd < mr) begin
                    prev = best;
                    pa = 1'b1;
                end else begin
                    break;
                end
            end
        end
    endtask

    // Per-cycle compare against the model timeline; t counts cycles after the start edge
    logic chk_en = 1'b0;
    int   chk_t, ck;
    always @(negedge clk) begin
        if (chk_en) begin
            ck = chk_t / (L + 1);
            if (ck > m_p) ck = m_p;
            chk("busy", int'(o_busy), int'(chk_t <= m_p * (L + 1)));
            chk("done", int'(o_done), int'(chk_t == m_p * (L + 1)));
            if (ck == 0) begin
                chk("c1x", int'(o_c1x), 0);
                chk("c1y", int'(o_c1y), 0);
                chk("c2x", int'(o_c2x), 0);
                chk("c2y", int'(o_c2y), 0);
            end else begin
                chk("c1x", int'(o_c1x), m_c1x[ck-1]);
                chk("c1y", int'(o_c1y), m_c1y[ck-1]);
                chk("c2x", int'(o_c2x), m_c2x[ck-1]);
                chk("c2y", int'(o_c2y), m_c2y[ck-1]);
                chk("cover_cnt", int'(o_cov), m_cov[ck-1]);
            end
            chk_t++;
            if (chk_t > m_p * (L + 1) + 2) chk_en = 1'b0;
        end
    end

    task automatic do_run(input bit use_b, input int mr, input int poke_at);
        run_model(mr);
        sel = use_b;
        @(negedge clk);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        chk_t  = 0;
        chk_en = 1'b1;
        if (poke_at > 0) begin
            repeat (poke_at) @(negedge clk);
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
        end
        wait (!chk_en);
    endtask

    task automatic fill(input int x0, input int y0, input int x1, input int y1, input int split);
        for (int i = 0; i < NP; i++) begin
            px[i] = (i < split) ? 4'(x0) : 4'(x1);
            py[i] = (i < split) ? 4'(y0) : 4'(y1);
        end
    endtask

    task automatic chk_final(input string nm, input int c1x, input int c1y, input int cov);
        chk({nm, "_C1X"}, int'(o_c1x), c1x);
        chk({nm, "_C1Y"}, int'(o_c1y), c1y);
        chk({nm, "_C2X"}, int'(o_c2x), 0);
        chk({nm, "_C2Y"}, int'(o_c2y), 0);
        chk({nm, "_cover"}, int'(o_cov), cov);
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
        fill(5, 5, 5, 5, NP);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_c1x", int'(c1x_a), 0);
        chk("rst_cover", int'(cov_a), 0);
        chk("rst_addr", int'(addr_a), 0);
        chk("rst_busy1", int'(busy_b), 0);
        rst = 1'b0;

        // Abort mid-search after the first phase has already published C1
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (L + 50) @(negedge clk);
        chk("pre_rst_c1y", int'(c1y_a), 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_done", int'(done_a), 0);
        chk("abort_c1x", int'(c1x_a), 0);
        chk("abort_c1y", int'(c1y_a), 0);
        chk("abort_c2x", int'(c2x_a), 0);
        chk("abort_c2y", int'(c2y_a), 0);
        chk("abort_cover", int'(cov_a), 0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("abort_idle_done", int'(done_a), 0);
            chk("abort_idle_busy", int'(busy_a), 0);
        end

        // All points on one spot: first covering candidate in row-major order is (5,1)
        fill(5, 5, 5, 5, NP);
        do_run(1'b0, 4, 0);
        chk("model_t1_phases", m_p, 4);
        chk("model_t1_c1y", m_c1y[m_p-1], 1);
        chk_final("t1", 5, 1, NP);

        // Two clusters: C2 at origin already covers (2,2)
        fill(2, 2, 12, 12, NP / 2);
        do_run(1'b0, 4, 0);
        chk("model_t2_phases", m_p, 4);
        chk("model_t2_c1x", m_c1x[m_p-1], 12);
        chk_final("t2", 12, 8, NP);

        // Radius boundary: distance^2 of exactly 16 counts
        fill(15, 15, 15, 15, NP);
        do_run(1'b0, 4, 0);
        chk("model_t3_c1y", m_c1y[m_p-1], 11);
        chk_final("t3", 15, 11, NP);

        // start pulsed mid-search must not disturb timing or result
        fill(2, 2, 12, 12, NP / 2);
        do_run(1'b0, 4, 300);
        chk_final("t4", 12, 8, NP);

        // Spread points, single-round limit
        px[0] = 4'd1;  py[0] = 4'd1;
        px[1] = 4'd3;  py[1] = 4'd3;
        px[2] = 4'd8;  py[2] = 4'd8;
        px[3] = 4'd10; py[3] = 4'd10;
        px[4] = 4'd14; py[4] = 4'd2;
        px[5] = 4'd2;  py[5] = 4'd14;
        px[6] = 4'd14; py[6] = 4'd14;
        px[7] = 4'd7;  py[7] = 4'd1;
        do_run(1'b1, 1, 0);
        chk("model_t5_phases", m_p, 2);
        chk("t5_done_low", int'(done_b), 0);
        chk("t5_busy_low", int'(busy_b), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/laser_cover_scheduler.md
Name: laser_cover_scheduler

Overview:
- Search controller for the two-circle laser coverage problem.
- The 40 target points sit in a point buffer that is already loaded and read combinationally. This block sequences alternating sweeps of candidate circle centres over the 16x16 grid. For each candidate it counts covered points one point per cycle and keeps the best.
- It alternates optimising C1 (C2 fixed) and C2 (C1 fixed) until the coverage count stops improving, then presents C1/C2 and pulses DONE.

Parameters:
- NPTS, 40, number of points in buffer (addresses 0..NPTS-1)
- RADIUS_SQ, 16, squared circle radius; a point is covered when dx^2+dy^2 <= RADIUS_SQ
- MAX_ROUNDS, 4, maximum A+B rounds before forced termination

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- start  in  1  begin search; sampled only in IDLE
- pt_x  in  4  X of point at pt_addr, valid same cycle
- pt_y  in  4  Y of point at pt_addr, valid same cycle
- pt_addr  out  6  point buffer read address
- C1X  out  4  circle 1 centre X
- C1Y  out  4  circle 1 centre Y
- C2X  out  4  circle 2 centre X
- C2Y  out  4  circle 2 centre Y
- cover_cnt  out  6  points covered by union of C1, C2 at last phase end
- busy  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse, result valid

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high, with priority over everything.
  - State goes to IDLE.
  - C1X/C1Y/C2X/C2Y, cover_cnt, pt_addr, busy and DONE all go to 0.
  - All internal counters and bests clear.
  - RST mid-scan aborts the search; no DONE is produced.
- States: IDLE, SCAN, EVAL, PHASE_END, DONE_ST.
- IDLE:
  - On start=1: C1=(0,0), C2=(0,0), round=0, prev_best=0, phase=A, candidate=(0,0), pt_addr=0, acc=0, phase_best=0, phase_best_pos=(0,0); go to SCAN.
  - start in any other state is ignored.
- SCAN (one point per cycle):
  - hit = in(candidate) OR in(fixed circle). The fixed circle is C2 in phase A and C1 in phase B.
  - in(c): dx=|pt_x-cx|, dy=|pt_y-cy| (4-bit unsigned); dx^2, dy^2 are 8-bit; the sum is 9-bit; compare <= RADIUS_SQ. No wrap-around: the grid is not toroidal.
  - acc += hit. acc is 6 bits and never overflows, since it is at most NPTS.
  - When pt_addr==NPTS-1, go to EVAL. Otherwise pt_addr+1.
- EVAL (1 cycle):
  - If acc > phase_best (strictly), load phase_best=acc and phase_best_pos=candidate. Ties keep the earlier candidate.
  - Advance candidate row-major: x inner 0..15, y outer 0..15.
  - If candidate was (15,15), go to PHASE_END. Else acc=0, pt_addr=0, back to SCAN.
- Timing: each candidate costs NPTS+1 cycles; each phase costs 256*(NPTS+1) cycles plus 1.
- PHASE_END:
  - Phase A: C1=phase_best_pos, cover_cnt=phase_best. Switch to phase B, restart the sweep at (0,0) with phase_best=0; go to SCAN.
  - Phase B: C2=phase_best_pos, cover_cnt=phase_best, round+1.
    - If phase_best > prev_best and round+1 < MAX_ROUNDS: prev_best=phase_best, switch to phase A, restart the sweep, go to SCAN.
    - Otherwise go to DONE_ST.
- DONE_ST: DONE=1 for exactly one cycle, busy=1; then IDLE. Outputs hold until the next start or RST.
- C1/C2 only change at PHASE_END, so they are stable throughout a sweep.

Test Plan:
- RST held 2 cycles mid-SCAN -> next cycle busy=0, DONE=0, C1X..C2Y=0, cover_cnt=0; a following start completes normally.
- All 40 points at (5,5), start -> C1=(5,1), C2=(0,0), cover_cnt=40; DONE after 2 rounds (4 phases), about 4*256*41 cycles.
- 20 points at (2,2), 20 at (12,12) -> C1=(12,8), C2=(0,0), cover_cnt=40; DONE after 2 rounds.
- Radius boundary: all 40 points at (15,15) -> C1=(15,11) (distance exactly 4 counts; (12,12) at 18 does not), C2=(0,0), cover_cnt=40.
- start pulsed while busy -> ignored: no restart, and the same result/DONE timing as an undisturbed run.
- Points spread so coverage improves every round, with MAX_ROUNDS=1 -> DONE after phase B of round 1 regardless of improvement; DONE high exactly one cycle.
